// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state and command encodings, sequencer states, IEEE 1149.1 next-state function
package jtag_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR  = 4'h0,
    EXIT1_DR  = 4'h1,
    SHIFT_DR  = 4'h2,
    PAUSE_DR  = 4'h3,
    SEL_IR    = 4'h4,
    UPDATE_DR = 4'h5,
    CAP_DR    = 4'h6,
    SEL_DR    = 4'h7,
    EXIT2_IR  = 4'h8,
    EXIT1_IR  = 4'h9,
    SHIFT_IR  = 4'hA,
    PAUSE_IR  = 4'hB,
    RTI       = 4'hC,
    UPDATE_IR = 4'hD,
    CAP_IR    = 4'hE,
    TLR       = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_IR    = 2'b01,
    CMD_DR    = 2'b10,
    CMD_IDLE  = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_WAIT, S_DONE
  } seq_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:       tap_next = tms ? TLR       : RTI;
      RTI:       tap_next = tms ? SEL_DR    : RTI;
      SEL_DR:    tap_next = tms ? SEL_IR    : CAP_DR;
      CAP_DR:    tap_next = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  tap_next = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  tap_next = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  tap_next = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  tap_next = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: tap_next = tms ? SEL_DR    : RTI;
      SEL_IR:    tap_next = tms ? TLR       : CAP_IR;
      CAP_IR:    tap_next = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  tap_next = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  tap_next = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  tap_next = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  tap_next = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: tap_next = tms ? SEL_DR    : RTI;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_mirror.sv
// jtag_tap_mirror: registered copy of the 16-state TAP controller driven by the TMS it sees
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e tap_state
);
  // follow the TAP on the same edge it samples tms
  always_ff @(posedge tck or posedge trst)
    if (trst) tap_state <= TLR;
    else tap_state <= tap_next(tap_state, tms);
endmodule

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: turns reset/IR/DR/idle commands into TMS/TDI streams and collects TDO (option: JTAG_SCAN_TLR_PARK_EN)
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic [3:0]         tap_state
);
  seq_state_e         seq, nseq;
  cmd_type_e          op;
  tap_state_e         mstate;
  logic [LEN_W-1:0]   cnt, ncnt, len;
  logic [MAX_LEN-1:0] sdat, cap;
  logic               walk, ntms, ntdi, accept, ir, pre_last;

  assign cmd_ready = seq == S_IDLE;
  assign rsp_valid = seq == S_DONE;
  assign accept    = cmd_valid && cmd_ready;
  assign tap_state = mstate;
  assign ir        = op == CMD_IR;
  assign pre_last  = cnt == (ir ? LEN_W'(3) : LEN_W'(2));

  jtag_tap_mirror u_mirror (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms_o),
    .tap_state (mstate)
  );

  // next sequencer step and the TMS/TDI values to present during it
  always_comb begin
    nseq = seq;
    ncnt = cnt + LEN_W'(1);
    ntms = 1'b0;
    ntdi = 1'b0;
    case (seq)
      S_INIT: nseq = tms_o ? S_INIT : S_IDLE;
      S_IDLE:
        if (cmd_valid) begin
          ncnt = '0;
          nseq = cmd_type == CMD_IDLE ? (cmd_len == '0 ? S_DONE : S_WAIT) : cmd_type == CMD_RESET ? S_WAIT : S_PRE;
          ntms = cmd_type != CMD_IDLE;
        end
      S_PRE:
        if (pre_last) begin
          nseq = S_SHIFT;
          ncnt = '0;
          ntms = len == LEN_W'(1);
          ntdi = sdat[0];
        end else ntms = ir && cnt == '0;
      S_SHIFT:
        if (cnt == len - LEN_W'(1)) begin
          nseq = S_POST;
          ncnt = '0;
          ntms = 1'b1;
        end else begin
          ntms = ncnt == len - LEN_W'(1);
          ntdi = sdat[1];
        end
      S_POST:
        if (cnt != '0) begin
`ifdef JTAG_SCAN_TLR_PARK_EN
          nseq = S_WAIT;
          ncnt = '0;
          ntms = 1'b1;
`else
          nseq = S_DONE;
`endif
        end
      S_WAIT:
        if (walk ? cnt == LEN_W'(5) : cnt == len - LEN_W'(1)) nseq = S_DONE;
        else ntms = walk && ncnt != LEN_W'(5);
      S_DONE: nseq = S_IDLE;
      default: nseq = S_INIT;
    endcase
  end

  // sequencer state, step counter and registered pin drivers
  always_ff @(posedge tck or posedge trst)
    if (trst) begin
      seq   <= S_INIT;
      cnt   <= '0;
      tms_o <= 1'b1;
      tdi_o <= 1'b0;
    end else begin
      seq   <= nseq;
      cnt   <= ncnt;
      tms_o <= ntms;
      tdi_o <= ntdi;
    end

  // latched command, TDI shifter, TDO capture and the response register
  always_ff @(posedge tck or posedge trst)
    if (trst) begin
      op       <= CMD_RESET;
      len      <= '0;
      sdat     <= '0;
      walk     <= 1'b0;
      cap      <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        op   <= cmd_type_e'(cmd_type);
        len  <= (cmd_len == '0 && cmd_type != CMD_IDLE) ? LEN_W'(1) : cmd_len;
        sdat <= cmd_data;
        walk <= cmd_type == CMD_RESET;
      end else if (seq == S_SHIFT) sdat <= sdat >> 1;
`ifdef JTAG_SCAN_TLR_PARK_EN
      if (seq == S_POST && nseq == S_WAIT) walk <= 1'b1;
`endif
      cap <= accept ? '0 : (mstate == SHIFT_DR || mstate == SHIFT_IR) ? {tdo_i, cap[MAX_LEN-1:1]} : cap;
      if (nseq == S_DONE && seq != S_DONE) rsp_data <= seq == S_IDLE ? '0 : cap >> (LEN_W'(MAX_LEN) - len);
    end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed and randomized commands checked against a cycle-level protocol model
module tb_jtag_scan_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               tck = 1'b0;
  logic               trst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_type = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               tdo_r = 1'b0;
  logic               loopback = 1'b0;
  logic               cmd_ready, tms_o, tdi_o, tdo_i, rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic [3:0]         tap_state;
  int                 passed = 0;
  int                 total = 0;

  assign tdo_i = loopback ? tdi_o : tdo_r;

  always #5 tck = ~tck;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .tms_o     (tms_o),
    .tdi_o     (tdi_o),
    .tdo_i     (tdo_i),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tap_state (tap_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 60) begin
      @(negedge tck);
      w++;
    end
    chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_cmd(input int t, input int l, input logic [31:0] d, input bit loop);
    logic        tms_e[$];
    logic [31:0] exp_rsp = '0;
    int          pre = 0, el = l, n, shifts = 0, idx;
    bit          scan = (t == 1 || t == 2);
    bit          in_shift;
    if (scan && l == 0) el = 1;
    if (t == 0) begin
      repeat (5) tms_e.push_back(1'b1);
      tms_e.push_back(1'b0);
    end else if (t == 3) repeat (l) tms_e.push_back(1'b0);
    else begin
      pre = (t == 1) ? 4 : 3;
      tms_e.push_back(1'b1);
      if (t == 1) tms_e.push_back(1'b1);
      tms_e.push_back(1'b0);
      tms_e.push_back(1'b0);
      for (int i = 0; i < el; i++) tms_e.push_back(i == el - 1);
      tms_e.push_back(1'b1);
      tms_e.push_back(1'b0);
    end
    n = tms_e.size();
    wait_ready();
    cmd_valid = 1'b1;
    cmd_type = 2'(t);
    cmd_len = LEN_W'(l);
    cmd_data = d;
    loopback = loop;
    @(negedge tck);
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom);
    cmd_len = LEN_W'($urandom);
    cmd_data = $urandom;
    for (int k = 1; k <= n; k++) begin
      in_shift = scan && k > pre && k <= pre + el;
      idx = k - pre - 1;
      chk("tms", {31'd0, tms_o}, {31'd0, tms_e[k-1]});
      chk("tdi", {31'd0, tdi_o}, {31'd0, in_shift ? d[idx] : 1'b0});
      chk("busy", {30'd0, rsp_valid, cmd_ready}, 32'd0);
      if (scan && tap_state === ((t == 1) ? 4'hA : 4'h2)) shifts++;
      if (!loop) tdo_r = 1'($urandom);
      if (in_shift) exp_rsp[idx] = loop ? d[idx] : tdo_r;
      @(negedge tck);
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ready_in_done", {31'd0, cmd_ready}, 32'd0);
    chk("rsp_data", rsp_data, exp_rsp);
    chk("end_state", {28'd0, tap_state}, 32'hC);
    if (scan) chk("shift_edges", shifts, el);
    @(negedge tck);
    chk("rsp_pulse", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    chk("rsp_hold", rsp_data, exp_rsp);
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge tck);
    chk("rst_tms", {31'd0, tms_o}, 32'd1);
    chk("rst_tdi", {31'd0, tdi_o}, 32'd0);
    chk("rst_hs", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_tap", {28'd0, tap_state}, 32'hF);
    trst = 1'b0;
    @(negedge tck);
    chk("init_tms", {31'd0, tms_o}, 32'd0);
    chk("init_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge tck);
    chk("init_done", {31'd0, cmd_ready}, 32'd1);
    chk("init_tap", {28'd0, tap_state}, 32'hC);
    run_cmd(0, 0, 32'd0, 1'b0);
    run_cmd(1, 4, 32'h0000000A, 1'b1);
    run_cmd(2, 32, 32'hDEADBEEF, 1'b1);
    run_cmd(3, 0, 32'd0, 1'b0);
    run_cmd(3, 3, 32'd0, 1'b0);
    run_cmd(2, 0, $urandom, 1'b0);
    run_cmd(1, 32, $urandom, 1'b0);
    for (int i = 0; i < 14; i++) run_cmd($urandom_range(0, 3), $urandom_range(0, 32), $urandom, 1'($urandom));
    wait_ready();
    d = $urandom;
    cmd_valid = 1'b1;
    cmd_type = 2'd2;
    cmd_len = LEN_W'(32);
    cmd_data = d;
    loopback = 1'b1;
    @(negedge tck);
    cmd_valid = 1'b0;
    repeat (13) @(negedge tck);
    chk("abort_tdi_b10", {31'd0, tdi_o}, {31'd0, d[10]});
    chk("abort_in_shift", {28'd0, tap_state}, 32'h2);
    #2 trst = 1'b1;
    #1;
    chk("abort_tms", {31'd0, tms_o}, 32'd1);
    chk("abort_tap", {28'd0, tap_state}, 32'hF);
    chk("abort_hs", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    repeat (2) begin
      @(negedge tck);
      chk("abort_hold", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    end
    trst = 1'b0;
    @(negedge tck);
    chk("reinit_tms", {31'd0, tms_o}, 32'd0);
    chk("reinit_hs", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    chk("reinit_tap", {28'd0, tap_state}, 32'hF);
    @(negedge tck);
    chk("reinit_ready", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    chk("reinit_rti", {28'd0, tap_state}, 32'hC);
    run_cmd(2, 17, $urandom, 1'b0);
    run_cmd(3, 32, 32'd0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
